// File: rtl/pio_pkg.sv
// Shared constants for the Avalon-MM PIO family: register map, edge sense and
// interrupt source encodings.
package pio_pkg;

    typedef enum logic [1:0] {
        PIO_ADDR_DATA    = 2'd0,
        PIO_ADDR_RSVD    = 2'd1,
        PIO_ADDR_IRQMASK = 2'd2,
        PIO_ADDR_EDGECAP = 2'd3
    } pio_addr_e;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/pio_sync.sv
// Multi-flop synchroniser for asynchronous PIO inputs; shared by the input,
// output and bidirectional PIO variants.
module pio_sync #(
    parameter int WIDTH  = 17,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain_q [STAGES];
    logic [WIDTH-1:0] chain_d [STAGES];

    always_comb begin
        chain_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
            chain_d[i] = chain_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STAGES; i++) begin
                chain_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                chain_q[i] <= chain_d[i];
            end
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/avalon_pio_in_irq.sv
// Input-only Avalon-MM PIO slave with synchronised data read, sticky per-bit
// edge capture, interrupt mask and a registered interrupt request.
module avalon_pio_in_irq
    import pio_pkg::*;
#(
    parameter int WIDTH       = 17,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0,
    parameter int IRQ_MODE    = 1,
    parameter int BIT_CLEAR   = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] ec_q, ec_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] rd_sel;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;
    logic             wr_mask, wr_ec;

    pio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (in_port),
        .q       (sync_q)
    );

    generate
        if (EDGE_TYPE == EDGE_RISING) begin : g_rise
            assign edge_det = sync_q & ~prev_q;
        end else if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
            assign edge_det = ~sync_q & prev_q;
        end else begin : g_any
            assign edge_det = sync_q ^ prev_q;
        end

        if (WIDTH < 32) begin : g_wdata_hi
            logic unused_wdata;
            assign unused_wdata = ^writedata[31:WIDTH];
        end
    endgenerate

    assign wr_mask = chipselect && write && (address == PIO_ADDR_IRQMASK);
    assign wr_ec   = chipselect && write && (address == PIO_ADDR_EDGECAP);

    always_comb begin
        prev_d     = sync_q;
        clr        = '0;
        mask_d     = mask_q;
        rd_sel     = '0;
        readdata_d = '0;
        irq_d      = 1'b0;

        if (wr_ec) begin
            clr = (BIT_CLEAR == 1) ? writedata[WIDTH-1:0] : '1;
        end
        // New edges win over a same-cycle clear of the same bit.
        ec_d = (ec_q & ~clr) | edge_det;

        if (wr_mask) begin
            mask_d = writedata[WIDTH-1:0];
        end

        // Read mux uses pre-write register values.
        case (address)
            PIO_ADDR_DATA:    rd_sel = sync_q;
            PIO_ADDR_IRQMASK: rd_sel = mask_q;
            PIO_ADDR_EDGECAP: rd_sel = ec_q;
            default:          rd_sel = '0;
        endcase
        readdata_d[WIDTH-1:0] = rd_sel;

        if (IRQ_MODE == IRQ_EDGE) begin
            irq_d = |(ec_q & mask_q);
        end else begin
            irq_d = |(sync_q & mask_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= '0;
            ec_q       <= '0;
            mask_q     <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            ec_q       <= ec_d;
            mask_q     <= mask_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_avalon_pio_in_irq.sv
// Bench for avalon_pio_in_irq: three parameterisations on a shared bus, each
// compared every cycle against a behavioural model, plus directed checks.
module tb_avalon_pio_in_irq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write;
    logic [31:0] writedata;
    logic [16:0] in0;
    logic [31:0] in1;
    logic [7:0]  in2;
    logic [31:0] rd0, rd1, rd2;
    logic        irq0, irq1, irq2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    avalon_pio_in_irq #(.WIDTH(17), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_MODE(1), .BIT_CLEAR(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write(write),
        .writedata(writedata), .in_port(in0), .readdata(rd0), .irq(irq0));

    avalon_pio_in_irq #(.WIDTH(32), .SYNC_STAGES(3), .EDGE_TYPE(2), .IRQ_MODE(0), .BIT_CLEAR(0)) dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write(write),
        .writedata(writedata), .in_port(in1), .readdata(rd1), .irq(irq1));

    avalon_pio_in_irq #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(1), .IRQ_MODE(1), .BIT_CLEAR(1)) dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write(write),
        .writedata(writedata), .in_port(in2), .readdata(rd2), .irq(irq2));

    // Reference model: configuration and architectural state per instance.
    int          m_w [3];
    int          m_ss[3];
    int          m_et[3];
    int          m_im[3];
    int          m_bc[3];
    logic [31:0] hist[3][4];
    logic [31:0] m_prev[3];
    logic [31:0] m_ec  [3];
    logic [31:0] m_mask[3];
    logic [31:0] m_rd  [3];
    logic        m_irq [3];

    function automatic logic [31:0] wmask(int k);
        return (m_w[k] >= 32) ? 32'hFFFF_FFFF : ((32'd1 << m_w[k]) - 32'd1);
    endfunction

    function automatic logic [31:0] in_val(int k);
        case (k)
            0:       return {15'd0, in0};
            1:       return in1;
            default: return {24'd0, in2};
        endcase
    endfunction

    function automatic logic [31:0] obs_rd(int k);
        case (k)
            0:       return rd0;
            1:       return rd1;
            default: return rd2;
        endcase
    endfunction

    function automatic logic obs_irq(int k);
        case (k)
            0:       return irq0;
            1:       return irq1;
            default: return irq2;
        endcase
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            for (int s = 0; s < 4; s++) hist[k][s] = '0;
            m_prev[k] = '0;
            m_ec[k]   = '0;
            m_mask[k] = '0;
            m_rd[k]   = '0;
            m_irq[k]  = 1'b0;
        end
    endtask

    task automatic model_step();
        logic [31:0] s, e, clr, wm;
        if (!reset_n) begin
            model_clear();
            return;
        end
        for (int k = 0; k < 3; k++) begin
            wm = wmask(k);
            s  = hist[k][m_ss[k]-1];
            case (m_et[k])
                0:       e = s & ~m_prev[k];
                1:       e = ~s & m_prev[k];
                default: e = s ^ m_prev[k];
            endcase
            e   = e & wm;
            clr = '0;
            if (chipselect && write && address == 2'd3) clr = (m_bc[k] == 1) ? (writedata & wm) : wm;
            case (address)
                2'd0:    m_rd[k] = s;
                2'd2:    m_rd[k] = m_mask[k];
                2'd3:    m_rd[k] = m_ec[k];
                default: m_rd[k] = '0;
            endcase
            m_irq[k] = (m_im[k] == 1) ? |(m_ec[k] & m_mask[k]) : |(s & m_mask[k]);
            m_ec[k]  = (m_ec[k] & ~clr) | e;
            if (chipselect && write && address == 2'd2) m_mask[k] = writedata & wm;
            m_prev[k] = s;
            for (int j = 3; j > 0; j--) hist[k][j] = hist[k][j-1];
            hist[k][0] = in_val(k) & wm;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("model_rd%0d", k), obs_rd(k), m_rd[k]);
            check($sformatf("model_irq%0d", k), {31'd0, obs_irq(k)}, {31'd0, m_irq[k]});
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write      = 1'b1;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write      = 1'b0;
        writedata  = '0;
    endtask

    initial begin
        m_w  = '{17, 32, 8};
        m_ss = '{2, 3, 2};
        m_et = '{0, 2, 1};
        m_im = '{1, 0, 1};
        m_bc = '{1, 0, 1};
        reset_n = 1'b0; address = '0; chipselect = 1'b0; write = 1'b0; writedata = '0;
        in0 = '0; in1 = '0; in2 = '0;
        model_clear();
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (3) tick();
        check("reset_rd0", rd0, 32'h0);
        check("reset_irq0", {31'd0, irq0}, 32'h0);

        // Latency: rising edge on bit 3 with mask 0x8.
        bus_write(2'd2, 32'h8);
        address = 2'd3;
        tick();
        in0[3] = 1'b1;
        in1    = 32'hF0;
        tick(); tick(); tick();
        check("lat_irq_early", {31'd0, irq0}, 32'h0);
        tick();
        check("lat_irq", {31'd0, irq0}, 32'h1);
        check("lat_ec", rd0, 32'h8);
        address = 2'd0;
        tick();
        check("lat_data", rd0, 32'h8);

        // Clear: W1C on dut0, clear-all on dut1.
        in0[0] = 1'b1;
        repeat (4) tick();
        bus_write(2'd2, 32'h1);
        address = 2'd3;
        tick();
        check("clr_pre", rd0, 32'h9);
        bus_write(2'd3, 32'h8);
        check("clr_rdwr_same", rd0, 32'h9);
        address = 2'd3;
        tick();
        check("clr_w1c", rd0, 32'h1);
        check("clr_irq", {31'd0, irq0}, 32'h1);
        check("clr_all", rd1, 32'h0);

        // Collision: clear of bit 0 coincides with its new rising edge.
        in0[0] = 1'b0;
        repeat (4) tick();
        in0[0] = 1'b1;
        tick(); tick();
        bus_write(2'd3, 32'h1);
        address = 2'd3;
        tick();
        check("collision", rd0 & 32'h1, 32'h1);

        // Falling-edge capture on dut2.
        bus_write(2'd3, 32'hFF);
        address = 2'd3;
        in2[0] = 1'b1;
        repeat (4) tick();
        check("fall_on_rise", rd2, 32'h0);
        in2[0] = 1'b0;
        repeat (4) tick();
        check("fall_on_fall", rd2, 32'h1);

        // Any-edge capture on dut1.
        bus_write(2'd3, 32'h0);
        address = 2'd3;
        tick();
        in1 = 32'hF1;
        repeat (5) tick();
        check("any_rise", rd1, 32'h1);
        bus_write(2'd3, 32'h0);
        address = 2'd3;
        tick();
        check("any_cleared", rd1, 32'h0);
        in1 = 32'hF0;
        repeat (5) tick();
        check("any_fall", rd1, 32'h1);

        // Level interrupt on the 32-bit instance, then reserved read.
        bus_write(2'd2, 32'h8000_0000);
        in1[31] = 1'b1;
        repeat (5) tick();
        check("lvl_irq_on", {31'd0, irq1}, 32'h1);
        in1[31] = 1'b0;
        repeat (3) tick();
        check("lvl_irq_hold", {31'd0, irq1}, 32'h1);
        tick();
        check("lvl_irq_off", {31'd0, irq1}, 32'h0);
        address = 2'd1;
        tick();
        check("rsvd_rd1", rd1, 32'h0);
        check("rsvd_rd0", rd0, 32'h0);

        // Masking a pending capture drops irq one cycle after the write.
        bus_write(2'd3, 32'hFFFF_FFFF);
        in0 = '0;
        repeat (4) tick();
        in0 = 17'h1;
        repeat (4) tick();
        bus_write(2'd2, 32'h1);
        tick();
        check("mask_irq_on", {31'd0, irq0}, 32'h1);
        bus_write(2'd2, 32'h0);
        check("mask_irq_same", {31'd0, irq0}, 32'h1);
        tick();
        check("mask_irq_drop", {31'd0, irq0}, 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            in0        = 17'($urandom);
            in1        = $urandom;
            in2        = 8'($urandom);
            address    = 2'($urandom_range(0, 3));
            chipselect = 1'($urandom_range(0, 1));
            write      = ($urandom_range(0, 3) == 0);
            writedata  = $urandom;
            tick();
        end
        chipselect = 1'b0; write = 1'b0;

        // Mid-run reset with a pending interrupt and all inputs high.
        bus_write(2'd2, 32'hFFFF_FFFF);
        in0 = '0;
        repeat (4) tick();
        in0 = '1; in1 = '1; in2 = '1;
        repeat (4) tick();
        check("pre_reset_irq", {31'd0, irq0}, 32'h1);
        reset_n = 1'b0;
        #1;
        model_clear();
        check("async_rst_rd0", rd0, 32'h0);
        check("async_rst_irq0", {31'd0, irq0}, 32'h0);
        check("async_rst_rd1", rd1, 32'h0);
        repeat (2) tick();
        reset_n = 1'b1;
        address = 2'd0;
        repeat (3) tick();
        check("post_rst_data0", rd0, 32'h0001_FFFF);
        tick();
        check("post_rst_data1", rd1, 32'hFFFF_FFFF);
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
